// File: rtl/prs_pkg.sv
// Shared constants and helpers for the parametrised PRS generator:
// default Galois tap masks, the single-step LFSR function and parameter checks.
package prs_pkg;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'hA3000000;

    localparam int unsigned LFSR_W_MIN = 4;
    localparam int unsigned LFSR_W_MAX = 32;
    localparam int unsigned OUT_W_MIN  = 1;
    localparam int unsigned OUT_W_MAX  = 32;

    // Right-shifting Galois step; callers zero-extend narrower states and taps.
    function automatic logic [31:0] galois_next(input logic [31:0] state,
                                                input logic [31:0] taps);
        return (state >> 1) ^ (state[0] ? taps : 32'h0);
    endfunction

    function automatic bit params_ok(input int unsigned lfsr_w,
                                     input int unsigned out_w,
                                     input logic [31:0] seed);
        return (lfsr_w >= LFSR_W_MIN) && (lfsr_w <= LFSR_W_MAX) &&
               (out_w >= OUT_W_MIN) && (out_w <= OUT_W_MAX) && (seed != 32'h0);
    endfunction

endpackage

// File: rtl/prs_lfsr_core.sv
// Galois LFSR state register: steps on request, loads a runtime seed and
// substitutes the fallback seed (with a one-cycle LOCKUP pulse) for a zero seed.
module prs_lfsr_core
    import prs_pkg::*;
#(
    parameter int unsigned         WIDTH = 16,
    parameter logic [WIDTH-1:0]    TAPS  = WIDTH'(TAPS_16),
    parameter logic [WIDTH-1:0]    SEED  = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] next_state;
    logic             lockup_q, lockup_d;

    assign next_state = WIDTH'(galois_next(32'(state_q), 32'(TAPS)));

    // Load beats step; an all-zero seed would freeze the LFSR forever.
    always_comb begin
        state_d  = state_q;
        lockup_d = 1'b0;
        if (load_i) begin
            if (seed_i == '0) begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d  = seed_i;
            end
        end else if (step_i) begin
            state_d = next_state;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= SEED;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
        end
    end

    assign state_o  = state_q;
    assign lockup_o = lockup_q;

endmodule

// File: rtl/prs_gen_param.sv
// Parametrised PRS generator: LFSR core plus an LSB-first word packer that
// hands completed words out over a registered valid/ready interface.
module prs_gen_param
    import prs_pkg::*;
#(
    parameter int unsigned              LFSR_WIDTH = 16,
    parameter int unsigned              OUT_WIDTH  = 8,
    parameter logic [LFSR_WIDTH-1:0]    TAPS       = LFSR_WIDTH'(TAPS_16),
    parameter logic [LFSR_WIDTH-1:0]    SEED       = LFSR_WIDTH'(1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  LOAD,
    input  logic [LFSR_WIDTH-1:0] SEED_IN,
    output logic [OUT_WIDTH-1:0]  OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [OUT_WIDTH-1:0]  PARTIAL_PRS,
    output logic [LFSR_WIDTH-1:0] STATE,
    output logic                  LOCKUP
);

    if (!params_ok(LFSR_WIDTH, OUT_WIDTH, 32'(SEED))) begin : g_param_err
        $error("prs_gen_param: widths out of range or zero SEED");
    end

    localparam int unsigned    CNT_W    = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_WIDTH - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]  partial_q, partial_d;
    logic [OUT_WIDTH-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic [OUT_WIDTH-1:0]  assembled;
    logic [LFSR_WIDTH-1:0] state;
    logic                  last_bit, step, out_bit;

    // Only the step that would overwrite an unconsumed word is held back.
    assign last_bit  = (cnt_q == CNT_LAST);
    assign step      = EN && !LOAD && !(last_bit && valid_q && !OUT_READY);
    assign out_bit   = state[0];
    assign assembled = partial_q | (OUT_WIDTH'(out_bit) << cnt_q);

    prs_lfsr_core #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk_i    (CLK),
        .rst_i    (RST),
        .step_i   (step),
        .load_i   (LOAD),
        .seed_i   (SEED_IN),
        .state_o  (state),
        .lockup_o (LOCKUP)
    );

    always_comb begin
        cnt_d     = cnt_q;
        partial_d = partial_q;
        data_d    = data_q;
        valid_d   = valid_q;
        if (valid_q && OUT_READY) begin
            valid_d = 1'b0;
        end
        if (LOAD) begin
            cnt_d     = '0;
            partial_d = '0;
        end else if (step) begin
            if (last_bit) begin
                cnt_d     = '0;
                partial_d = '0;
                data_d    = assembled;
                valid_d   = 1'b1;
            end else begin
                cnt_d     = cnt_q + 1'b1;
                partial_d = assembled;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= '0;
            partial_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign OUT_DATA    = data_q;
    assign OUT_VALID   = valid_q;
    assign PARTIAL_PRS = partial_q;
    assign STATE       = state;

endmodule
